// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared opcode, func, ALU, pc_source and shift encodings for the control pipe
package ctrl_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_ADDU = 4'd11,
        ALU_SUBU = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JR   = 2'b01,
        PC_JUMP = 2'b11
    } pc_src_e;

    // Shift field: register shift by shamt, or LUI's shift-by-16 of the immediate.
    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_REG  = 2'b01;
    localparam logic [1:0] SHIFT_LUI  = 2'b10;

    // Width-independent part of the control bundle carried down the pipe.
    typedef struct packed {
        logic       alusrc;
        logic [1:0] shift;
        logic       signextend;
        logic       readmem;
        logic       writemem;
        logic       regwrite;
        logic       memtoreg;
        logic       link;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/func decoder producing the ID control bundle
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int ALUOP_W  = 4,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    output logic [ALUOP_W-1:0] aluop,
    output ctrl_t              ctrl,
    output logic [REG_W-1:0]   dst,
    output logic [1:0]         pc_source,
    output logic               branch,
    output logic               illegal,
    output logic [REG_W-1:0]   rs_read,
    output logic [REG_W-1:0]   rt_read
);

    alu_op_e          alu;
    logic [REG_W-1:0] dst_raw;
    logic             uses_rs;
    logic             uses_rt;

    // Decode table; an unknown op collapses back to the all-zero NOP bundle.
    always_comb begin
        alu       = ALU_NOP;
        ctrl      = '0;
        dst_raw   = '0;
        pc_source = PC_SEQ;
        branch    = 1'b0;
        illegal   = 1'b0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.regwrite = 1'b1;
                    dst_raw       = rd;
                    uses_rs       = 1'b1;
                    uses_rt       = 1'b1;
                    case (func)
                        F_ADD:  alu = ALU_ADD;
                        F_ADDU: alu = ALU_ADDU;
                        F_SUB:  alu = ALU_SUB;
                        F_SUBU: alu = ALU_SUBU;
                        F_AND:  alu = ALU_AND;
                        F_OR:   alu = ALU_OR;
                        F_XOR:  alu = ALU_XOR;
                        F_NOR:  alu = ALU_NOR;
                        F_SLT:  alu = ALU_SLT;
                        F_SLL, F_SRL, F_SRA: begin
                            alu        = (func == F_SLL) ? ALU_SLL :
                                         (func == F_SRL) ? ALU_SRL : ALU_SRA;
                            ctrl.shift = SHIFT_REG;
                            uses_rs    = 1'b0;
                        end
                        F_JR: begin
                            pc_source     = PC_JR;
                            branch        = 1'b1;
                            ctrl.regwrite = 1'b0;
                            uses_rt       = 1'b0;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                OP_ADDI, OP_ADDIU, OP_SLTI: begin
                    alu             = (opcode == OP_ADDI)  ? ALU_ADD :
                                      (opcode == OP_ADDIU) ? ALU_ADDU : ALU_SLT;
                    ctrl.alusrc     = 1'b1;
                    ctrl.signextend = 1'b1;
                    ctrl.regwrite   = 1'b1;
                    dst_raw         = rt;
                    uses_rs         = 1'b1;
                end
                OP_ANDI, OP_ORI: begin
                    alu           = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    dst_raw       = rt;
                    uses_rs       = 1'b1;
                end
                OP_LUI: begin
                    alu           = ALU_SLL;
                    ctrl.shift    = SHIFT_LUI;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    dst_raw       = rt;
                end
                OP_LW: begin
                    alu             = ALU_ADD;
                    ctrl.alusrc     = 1'b1;
                    ctrl.signextend = 1'b1;
                    ctrl.readmem    = 1'b1;
                    ctrl.memtoreg   = 1'b1;
                    ctrl.regwrite   = 1'b1;
                    dst_raw         = rt;
                    uses_rs         = 1'b1;
                end
                OP_SW: begin
                    alu             = ALU_ADD;
                    ctrl.alusrc     = 1'b1;
                    ctrl.signextend = 1'b1;
                    ctrl.writemem   = 1'b1;
                    uses_rs         = 1'b1;
                    uses_rt         = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BGTZ, OP_BGEZ: begin
                    alu             = ALU_SUB;
                    branch          = 1'b1;
                    ctrl.signextend = 1'b1;
                    uses_rs         = 1'b1;
                    uses_rt         = (opcode == OP_BEQ) || (opcode == OP_BNE);
                end
                OP_J: pc_source = PC_JUMP;
                OP_JAL: begin
                    pc_source     = PC_JUMP;
                    ctrl.regwrite = 1'b1;
                    ctrl.link     = 1'b1;
                    dst_raw       = REG_W'(LINK_REG);
                end
                default: illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            alu       = ALU_NOP;
            ctrl      = '0;
            dst_raw   = '0;
            pc_source = PC_SEQ;
            branch    = 1'b0;
            uses_rs   = 1'b0;
            uses_rt   = 1'b0;
        end
    end

    // Unread source ports report register 0, which never matches a hazard destination.
    assign aluop   = ALUOP_W'(alu);
    assign dst     = ctrl.regwrite ? dst_raw : '0;
    assign rs_read = uses_rs ? rs : '0;
    assign rt_read = uses_rt ? rt : '0;

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID decode plus ID/EX, EX/MEM, MEM/WB control stages with load-use stall
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int ALUOP_W    = 4,
    parameter int REG_W      = 5,
    parameter int LOAD_DELAY = 1,
    parameter int LINK_REG   = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic               flush,
    input  logic               freeze,
    output logic [1:0]         id_pc_source,
    output logic               id_branch,
    output logic               id_illegal,
    output logic               hazard_stall,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic [1:0]         ex_shift,
    output logic               ex_signextend,
    output logic [REG_W-1:0]   ex_dst,
    output logic               mem_readmem,
    output logic               mem_writemem,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic               wb_link,
    output logic [REG_W-1:0]   wb_dst
);

    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_DELAY - 1);

    logic [ALUOP_W-1:0] dec_aluop;
    ctrl_t              dec_ctrl;
    logic [REG_W-1:0]   dec_dst;
    logic [REG_W-1:0]   rs_read;
    logic [REG_W-1:0]   rt_read;

    ctrl_t              ex_ctrl;
    logic               mem_regwrite;
    logic               mem_memtoreg;
    logic               mem_link;
    logic [REG_W-1:0]   mem_dst;
    logic [2:0]         stall_cnt;
    logic               hazard_hit;
    logic               flush_now;

    ctrl_decode #(
        .ALUOP_W  (ALUOP_W),
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .id_valid  (id_valid),
        .opcode    (opcode),
        .func      (func),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .aluop     (dec_aluop),
        .ctrl      (dec_ctrl),
        .dst       (dec_dst),
        .pc_source (id_pc_source),
        .branch    (id_branch),
        .illegal   (id_illegal),
        .rs_read   (rs_read),
        .rt_read   (rt_read)
    );

    // Only the live EX register is compared; rs_read/rt_read are 0 for unread ports.
    assign hazard_hit   = ex_ctrl.readmem && (ex_dst != '0) &&
                          ((rs_read == ex_dst) || (rt_read == ex_dst));
    // A frozen pipe ignores flush, so it cannot cancel a pending stall.
    assign flush_now    = flush && !freeze;
    assign hazard_stall = ((stall_cnt != 3'd0) || hazard_hit) && !flush_now;

    assign ex_alusrc     = ex_ctrl.alusrc;
    assign ex_shift      = ex_ctrl.shift;
    assign ex_signextend = ex_ctrl.signextend;

    // Stage registers and stall counter: freeze holds all, flush/stall bubble EX only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_aluop     <= ALUOP_W'(ALU_NOP);
            ex_ctrl      <= '0;
            ex_dst       <= '0;
            mem_readmem  <= 1'b0;
            mem_writemem <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_link     <= 1'b0;
            mem_dst      <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_link      <= 1'b0;
            wb_dst       <= '0;
            stall_cnt    <= 3'd0;
        end else if (!freeze) begin
            if (flush_now || hazard_stall) begin
                ex_aluop <= ALUOP_W'(ALU_NOP);
                ex_ctrl  <= '0;
                ex_dst   <= '0;
            end else begin
                ex_aluop <= dec_aluop;
                ex_ctrl  <= dec_ctrl;
                ex_dst   <= dec_dst;
            end
            mem_readmem  <= ex_ctrl.readmem;
            mem_writemem <= ex_ctrl.writemem;
            mem_regwrite <= ex_ctrl.regwrite;
            mem_memtoreg <= ex_ctrl.memtoreg;
            mem_link     <= ex_ctrl.link;
            mem_dst      <= ex_dst;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_link      <= mem_link;
            wb_dst       <= mem_dst;
            if (flush_now) begin
                stall_cnt <= 3'd0;
            end else if (stall_cnt != 3'd0) begin
                stall_cnt <= stall_cnt - 3'd1;
            end else if (hazard_hit) begin
                stall_cnt <= LOAD_RELOAD;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe at LOAD_DELAY 1 and 3
module tb_ctrl_pipe;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] shift;
        logic       sext;
        logic [4:0] dst;
        logic       rdm;
        logic       wrm;
        logic       rw;
        logic       m2r;
        logic       link;
    } bnd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] opcode, func;
    logic [4:0] rs, rt, rd;
    logic       flush, freeze;

    logic [1:0] o_pcs    [2];
    logic       o_br     [2];
    logic       o_ill    [2];
    logic       o_stall  [2];
    logic [3:0] o_aluop  [2];
    logic       o_alusrc [2];
    logic [1:0] o_shift  [2];
    logic       o_sext   [2];
    logic [4:0] o_exdst  [2];
    logic       o_rdm    [2];
    logic       o_wrm    [2];
    logic       o_rw     [2];
    logic       o_m2r    [2];
    logic       o_link   [2];
    logic [4:0] o_wbdst  [2];

    bnd_t m_ex [2];
    bnd_t m_mem[2];
    bnd_t m_wb [2];
    int   m_rem[2];
    int   dly  [2];
    int   st_cnt[2];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.LOAD_DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .freeze(freeze),
        .id_pc_source(o_pcs[0]), .id_branch(o_br[0]), .id_illegal(o_ill[0]),
        .hazard_stall(o_stall[0]), .ex_aluop(o_aluop[0]), .ex_alusrc(o_alusrc[0]),
        .ex_shift(o_shift[0]), .ex_signextend(o_sext[0]), .ex_dst(o_exdst[0]),
        .mem_readmem(o_rdm[0]), .mem_writemem(o_wrm[0]), .wb_regwrite(o_rw[0]),
        .wb_memtoreg(o_m2r[0]), .wb_link(o_link[0]), .wb_dst(o_wbdst[0])
    );

    ctrl_pipe #(.LOAD_DELAY(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .freeze(freeze),
        .id_pc_source(o_pcs[1]), .id_branch(o_br[1]), .id_illegal(o_ill[1]),
        .hazard_stall(o_stall[1]), .ex_aluop(o_aluop[1]), .ex_alusrc(o_alusrc[1]),
        .ex_shift(o_shift[1]), .ex_signextend(o_sext[1]), .ex_dst(o_exdst[1]),
        .mem_readmem(o_rdm[1]), .mem_writemem(o_wrm[1]), .wb_regwrite(o_rw[1]),
        .wb_memtoreg(o_m2r[1]), .wb_link(o_link[1]), .wb_dst(o_wbdst[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic void model_dec(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] t, input logic [4:0] d,
                                      output bnd_t b, output logic ill, output logic [1:0] pcs,
                                      output logic br, output logic urs, output logic urt);
        b = '0; ill = 1'b0; pcs = 2'b00; br = 1'b0; urs = 1'b0; urt = 1'b0;
        if (v) begin
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: b.aluop = 4'd1;
                        6'h21: b.aluop = 4'd11;
                        6'h22: b.aluop = 4'd2;
                        6'h23: b.aluop = 4'd12;
                        6'h24: b.aluop = 4'd3;
                        6'h25: b.aluop = 4'd4;
                        6'h26: b.aluop = 4'd5;
                        6'h27: b.aluop = 4'd6;
                        6'h2A: b.aluop = 4'd7;
                        6'h00: b.aluop = 4'd8;
                        6'h02: b.aluop = 4'd9;
                        6'h03: b.aluop = 4'd10;
                        6'h08: begin pcs = 2'b01; br = 1'b1; urs = 1'b1; end
                        default: ill = 1'b1;
                    endcase
                    if (!ill && fn != 6'h08) begin
                        b.rw = 1'b1; b.dst = d; urt = 1'b1;
                        if (fn <= 6'h03) b.shift = 2'b01;
                        else urs = 1'b1;
                    end
                end
                6'h08, 6'h09, 6'h0A: begin
                    b.aluop = (op == 6'h08) ? 4'd1 : (op == 6'h09) ? 4'd11 : 4'd7;
                    b.alusrc = 1'b1; b.sext = 1'b1; b.rw = 1'b1; b.dst = t; urs = 1'b1;
                end
                6'h0C, 6'h0D: begin
                    b.aluop = (op == 6'h0C) ? 4'd3 : 4'd4;
                    b.alusrc = 1'b1; b.rw = 1'b1; b.dst = t; urs = 1'b1;
                end
                6'h0F: begin
                    b.aluop = 4'd8; b.shift = 2'b10; b.alusrc = 1'b1; b.rw = 1'b1; b.dst = t;
                end
                6'h23: begin
                    b.aluop = 4'd1; b.alusrc = 1'b1; b.sext = 1'b1; b.rdm = 1'b1;
                    b.m2r = 1'b1; b.rw = 1'b1; b.dst = t; urs = 1'b1;
                end
                6'h2B: begin
                    b.aluop = 4'd1; b.alusrc = 1'b1; b.sext = 1'b1; b.wrm = 1'b1;
                    urs = 1'b1; urt = 1'b1;
                end
                6'h04, 6'h05, 6'h07, 6'h01: begin
                    b.aluop = 4'd2; br = 1'b1; b.sext = 1'b1; urs = 1'b1;
                    urt = (op == 6'h04) || (op == 6'h05);
                end
                6'h02: pcs = 2'b11;
                6'h03: begin pcs = 2'b11; b.rw = 1'b1; b.link = 1'b1; b.dst = 5'd31; end
                default: ill = 1'b1;
            endcase
        end
    endfunction

    function automatic logic model_stall(input int k, input bnd_t dummy);
        bnd_t b; logic ill, br, urs, urt; logic [1:0] pcs; logic hit;
        model_dec(id_valid, opcode, func, rt, rd, b, ill, pcs, br, urs, urt);
        hit = m_ex[k].rdm && (m_ex[k].dst != 5'd0) &&
              ((urs && rs == m_ex[k].dst) || (urt && rt == m_ex[k].dst));
        if (flush && !freeze) return 1'b0;
        return (m_rem[k] > 0) || hit || (dummy != dummy);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_rem[k] = 0;
        end
    endtask

    task automatic check_now();
        bnd_t b; logic ill, br, urs, urt; logic [1:0] pcs;
        model_dec(id_valid, opcode, func, rt, rd, b, ill, pcs, br, urs, urt);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("id_d%0d", dly[k]), {29'd0, o_pcs[k], o_br[k], o_ill[k]}, {29'd0, pcs, br, ill});
            chk($sformatf("stall_d%0d", dly[k]), {31'd0, o_stall[k]}, {31'd0, model_stall(k, b)});
            chk($sformatf("ex_d%0d", dly[k]),
                {19'd0, o_aluop[k], o_alusrc[k], o_shift[k], o_sext[k], o_exdst[k]},
                {19'd0, m_ex[k].aluop, m_ex[k].alusrc, m_ex[k].shift, m_ex[k].sext, m_ex[k].dst});
            chk($sformatf("mem_d%0d", dly[k]), {30'd0, o_rdm[k], o_wrm[k]}, {30'd0, m_mem[k].rdm, m_mem[k].wrm});
            chk($sformatf("wb_d%0d", dly[k]), {24'd0, o_rw[k], o_m2r[k], o_link[k], o_wbdst[k]},
                {24'd0, m_wb[k].rw, m_wb[k].m2r, m_wb[k].link, m_wb[k].dst});
            if (o_stall[k]) st_cnt[k]++;
        end
    endtask

    // A hazard books LOAD_DELAY stall cycles; each unfrozen stall cycle consumes one.
    task automatic model_advance();
        bnd_t b, nex; logic ill, br, urs, urt; logic [1:0] pcs; logic stl;
        model_dec(id_valid, opcode, func, rt, rd, b, ill, pcs, br, urs, urt);
        for (int k = 0; k < 2; k++) begin
            if (!freeze) begin
                stl = model_stall(k, b);
                nex = b;
                if (flush) begin
                    m_rem[k] = 0; nex = '0;
                end else if (stl) begin
                    if (m_rem[k] == 0) m_rem[k] = dly[k];
                    m_rem[k] = m_rem[k] - 1;
                    nex = '0;
                end
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                m_ex[k]  = nex;
            end
        end
    endtask

    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic fl, input logic fz);
        id_valid = v; opcode = op; func = fn; rs = s; rt = t; rd = d; flush = fl; freeze = fz;
        @(negedge clk);
        check_now();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        st_cnt[0] = 0; st_cnt[1] = 0;
    endtask

    logic [5:0] ops [18];
    logic [5:0] fns [14];

    initial begin
        dly[0] = 1; dly[1] = 3; st_cnt[0] = 0; st_cnt[1] = 0;
        ops = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08,
                6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h3F};
        fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
        rst = 1'b1; id_valid = 1'b0; opcode = '0; func = '0; rs = '0; rt = '0; rd = '0;
        flush = 1'b0; freeze = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_now();
        rst = 1'b0;

        // ADD r3,r1,r2 then SW
        step(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        chk("add_ex_aluop", {28'd0, o_aluop[0]}, 32'd1);
        chk("add_ex_dst", {27'd0, o_exdst[0]}, 32'd3);
        step(1'b1, 6'h2B, 6'h00, 5'd4, 5'd7, 5'd0, 1'b0, 1'b0);
        step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("sw_mem_writemem", {31'd0, o_wrm[0]}, 32'd1);
        chk("add_wb_regwrite", {31'd0, o_rw[0]}, 32'd1);
        chk("add_wb_dst", {27'd0, o_wbdst[0]}, 32'd3);
        step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("sw_wb_dst", {27'd0, o_wbdst[0]}, 32'd0);

        // LW r5 then ADD r6,r5,r1 held in ID across the stall
        drain();
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        chk("stall_len_d1", st_cnt[0], 32'd1);
        chk("stall_len_d3", st_cnt[1], 32'd3);

        // LW r0 never stalls
        drain();
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
        chk("lw_r0_stall_d1", st_cnt[0], 32'd0);
        chk("lw_r0_stall_d3", st_cnt[1], 32'd0);

        // Freeze for two cycles in the middle of a three-cycle stall
        drain();
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        chk("freeze_stall_d3", st_cnt[1], 32'd5);
        chk("freeze_stall_d1", st_cnt[0], 32'd1);

        // Flush in the same cycle as a hazard
        drain();
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        chk("flush_stall_d3", st_cnt[1], 32'd0);
        chk("flush_mem_lw_d1", {31'd0, o_rdm[0]}, 32'd1);
        chk("flush_mem_lw_d3", {31'd0, o_rdm[1]}, 32'd1);
        chk("flush_ex_bubble", {28'd0, o_aluop[1]}, 32'd0);

        // JAL then illegal opcode
        drain();
        step(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("jal_pc_source", {30'd0, o_pcs[0]}, 32'd3);
        step(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        chk("illegal_flag", {31'd0, o_ill[0]}, 32'd1);
        step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("jal_wb", {24'd0, o_rw[0], o_link[0], o_wbdst[0], 1'b0}, {24'd0, 1'b1, 1'b1, 5'd31, 1'b0});
        chk("illegal_ex_zero", {19'd0, o_aluop[0], o_alusrc[0], o_shift[0], o_sext[0], o_exdst[0]}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 17)], fns[$urandom_range(0, 13)],
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
        end

        // Asynchronous reset mid-stream, away from any clock edge
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_now();
        chk("rst_ex_aluop", {28'd0, o_aluop[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 17)], fns[$urandom_range(0, 13)],
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
